// File: rtl/irq_pending_unit.sv
// irq_pending_unit: front end of the interrupt controller.
// Synchronizes raw request lines, latches edges or passes levels into a
// pending register, tracks lost edges, and presents the masked request vector.
module irq_pending_unit #(
    parameter  int NUM_IRQ     = 4,
    parameter  int SYNC_STAGES = 2,
    localparam int ID_W        = $clog2(NUM_IRQ)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NUM_IRQ-1:0] i_irq_raw,
    input  logic [NUM_IRQ-1:0] i_edge_mode,
    input  logic [NUM_IRQ-1:0] i_mask,
    input  logic               i_ack,
    input  logic [ID_W-1:0]    i_ack_id,
    output logic [NUM_IRQ-1:0] o_irq,
    output logic [NUM_IRQ-1:0] o_pending,
    output logic [NUM_IRQ-1:0] o_overrun
);

    // Stage 0 samples the raw lines; the last stage is the synchronized value.
    logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] r_sync;
    logic [NUM_IRQ-1:0]                  r_prev;
    logic [NUM_IRQ-1:0]                  r_pending;
    logic [NUM_IRQ-1:0]                  r_overrun;

    logic [NUM_IRQ-1:0] w_sync;
    logic [NUM_IRQ-1:0] w_rise;
    logic [NUM_IRQ-1:0] w_ackHit;
    logic [NUM_IRQ-1:0] w_pendingNext;
    logic [NUM_IRQ-1:0] w_overrunNext;

    assign w_sync = r_sync[SYNC_STAGES-1];
    assign w_rise = w_sync & ~r_prev;

    // Decode the acknowledged id into a one-hot bit; id k names bit NUM_IRQ-1-k.
    always_comb begin
        w_ackHit = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (i_ack && (i_ack_id == ID_W'(NUM_IRQ - 1 - i))) begin
                w_ackHit[i] = 1'b1;
            end
        end
    end

    // Edge lines: a rise sets (beating a same-cycle ack), else an ack clears,
    // else hold. Level lines simply copy the synchronized input.
    assign w_pendingNext = (i_edge_mode & (w_rise | (r_pending & ~w_ackHit)))
                         | (~i_edge_mode & w_sync);

    // A rise onto an already pending edge bit is a lost edge unless the same
    // cycle acks it; an ack clears the flag when no new loss occurs.
    assign w_overrunNext = (i_edge_mode & w_rise & r_pending & ~w_ackHit)
                         | (r_overrun & ~w_ackHit);

    // Synchronizer chain per line, cleared asynchronously.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= i_irq_raw;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end
    end

    // Previous synchronized value for rise detection; zero after reset so a
    // line already high at release produces one rise.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev <= '0;
        end else begin
            r_prev <= w_sync;
        end
    end

    // Pending and overrun state registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pending <= '0;
            r_overrun <= '0;
        end else begin
            r_pending <= w_pendingNext;
            r_overrun <= w_overrunNext;
        end
    end

    assign o_irq     = r_pending & i_mask;
    assign o_pending = r_pending;
    assign o_overrun = r_overrun;

endmodule

// File: doc/irq_pending_unit.md
# irq_pending_unit

Upstream front end of `interrupt_controller`.
- Synchronizes raw asynchronous interrupt lines into the `clk` domain.
- Per line, either latches rising edges into sticky pending bits or passes levels through.
- Applies an enable mask and drives the `irq` vector that the priority encoder consumes.
- Retires edge-mode pending bits when the controller's winning `int_id` is acknowledged, and flags edges lost while a bit was already pending.

## Interface
- `NUM_IRQ`, default 4: number of interrupt lines. Must be ≥2 and a power of two.
- `SYNC_STAGES`, default 2: synchronizer depth per line. Must be ≥2.
- `ID_W`, default `$clog2(NUM_IRQ)`: width of `ack_id`. Derived; not overridden.
- `clk`  in  1  single clock; all flops on rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state while 0.
- `irq_raw`  in  NUM_IRQ  raw asynchronous request lines, active-high.
- `edge_mode`  in  NUM_IRQ  per line: 1 = rising-edge latched, 0 = level. Synchronous to `clk`.
- `mask`  in  NUM_IRQ  per line: 1 = enabled. Synchronous to `clk`.
- `ack`  in  1  one-cycle pulse that retires the pending bit selected by `ack_id`.
- `ack_id`  in  ID_W  id in controller numbering: id k ↔ bit NUM_IRQ-1-k (bit NUM_IRQ-1 is IRQ0, highest priority).
- `irq`  out  NUM_IRQ  `pending & mask`, combinational from registers; feeds the controller's `irq`.
- `pending`  out  NUM_IRQ  raw pending register, unmasked.
- `overrun`  out  NUM_IRQ  sticky lost-edge flags.

## Operation
- **Synchronizer.** Each line i passes through a `SYNC_STAGES` flop chain. Call the chain output `s[i]`.
- **Edge detect.** `prev[i]` holds `s[i]` from the previous cycle. `rise[i] = s[i] & ~prev[i]`.
- **Level mode** (`edge_mode[i]`=0):
  - `pending[i]` takes `s[i]` every cycle.
  - `ack` has no effect on the bit.
  - `overrun[i]` is never set.
- **Edge mode** (`edge_mode[i]`=1), next-state priority, evaluated per cycle:
  1. `rise[i]` sets `pending[i]`=1. This wins over a simultaneous ack of the same id.
  2. Otherwise, `ack` with `ack_id` mapping to bit i clears `pending[i]`.
  3. Otherwise, `pending[i]` holds.
- **Overrun.**
  - Set: edge mode, `rise[i]`=1, `pending[i]`=1 already, and no matching ack in that cycle.
  - Cleared: by a matching ack, unless a new overrun condition occurs in the same cycle (set wins).
  - A rise coinciding with its own ack is not an overrun; the new edge re-arms the bit.
- **Ack to a non-pending bit:** no effect, no error.
- **Mode switching.**
  - Edge→level: the pending bit follows `s[i]` from the next edge.
  - Level→edge: the pending bit keeps its current value, then edge rules apply.
- **Masking.**
  - Masked lines still latch pending and overrun.
  - Unmasking a pending line raises `irq[i]` in the same cycle (combinational).
  - Masking drops `irq[i]` in the same cycle.
- **Reset.** Asynchronous assert clears synchronizers, `prev`, `pending` and `overrun` immediately, including mid-operation. `irq`=0, `pending`=0, `overrun`=0.
- **Line already high at reset release.** `prev` resets to 0, so one rise is detected and latched in edge mode.

## Timing
- **Latency.** `irq_raw[i]` goes high before edge E0 (setup met). Then:
  - `s[i]` is high after edge E0+SYNC_STAGES-1.
  - `pending[i]` and `irq[i]` are high after E0+SYNC_STAGES, i.e. 3 edges for the default.
- **Ack latency.** Ack sampled at edge E clears `pending` and `irq` after E. The controller therefore sees the line drop on the next cycle.
- **Pulse width.** Raw pulses shorter than one `clk` period may be missed. Sources must hold ≥2 cycles.
- **Release latency.** Level-mode release follows the same `SYNC_STAGES`+1 edge latency as assertion.
- **Input sampling.** `mask`, `edge_mode`, `ack` and `ack_id` are sampled every edge. No handshake back-pressure exists.

## Test plan
- **Edge latch and ack.** Default params, `edge_mode`=4'b1111, `mask`=4'b1111. Raise `irq_raw`=4'b1000 for 2 cycles, then drop.
  - `pending`=4'b1000 and `irq`=4'b1000 at edge 3; bit stays set after the line drops.
  - `ack`=1, `ack_id`=0 → `pending`=4'b0000 next cycle.
- **Level mode.** `edge_mode`=0, raise `irq_raw`=4'b0011.
  - `irq`=4'b0011 after 3 edges.
  - Drop the lines → `irq`=4'b0000 after 3 edges.
  - `ack`, `ack_id`=3 has no effect while the lines are high.
- **Mask.** `mask`=4'b0111, edge on bit 3.
  - `pending`=4'b1000, `irq`=4'b0000.
  - Set `mask`=4'b1111 → `irq`=4'b1000 in the same cycle.
- **Overrun.** Edge on bit 1 (id 2). Drop it, then a second edge with no ack.
  - `overrun`=4'b0010.
  - `ack_id`=2 clears both `pending[1]` and `overrun[1]`.
- **Rise coinciding with ack.** Bit 0 pending; a new synchronized rise on bit 0 lands in the same cycle as `ack`, `ack_id`=3.
  - `pending[0]` stays 1, `overrun[0]` stays 0.
- **Reset.** Assert `reset`=0 mid-activity with `pending`=4'b1010.
  - All outputs 0 immediately, without waiting for `clk`.
  - Release with `irq_raw[2]` held high, edge mode → `pending`=4'b0100 three edges later.
